// File: rtl/alien_missile_if.sv
// Fire-request / missile-state bundle between alien fire logic, this bank and the renderer.
interface alien_missile_if #(
  parameter int NUM_MISSILES = 4
);
  logic                        fire_req;
  logic [9:0]                  fire_x;
  logic [9:0]                  fire_y;
  logic [NUM_MISSILES-1:0]     has_collided;
  logic                        fire_ack;
  logic [NUM_MISSILES-1:0]     exists;
  logic [10*NUM_MISSILES-1:0]  missile_x;
  logic [10*NUM_MISSILES-1:0]  missile_y;
  logic [3:0]                  active_count;

  modport master (
    output fire_req, fire_x, fire_y, has_collided,
    input  fire_ack, exists, missile_x, missile_y, active_count
  );

  modport slave (
    input  fire_req, fire_x, fire_y, has_collided,
    output fire_ack, exists, missile_x, missile_y, active_count
  );
endinterface

// File: rtl/alien_missile_bank.sv
// Pool of downward-moving alien missiles: round-robin slot allocation with launch cooldown,
// per-frame advance, retirement on collision or when the next step would pass the bottom row.
module alien_missile_bank #(
  parameter int NUM_MISSILES = 4,
  parameter int SPEED        = 4,
  parameter int X_OFFSET     = 14,
  parameter int Y_OFFSET     = 32,
  parameter int BOTTOM_Y     = 479,
  parameter int COOLDOWN     = 8
) (
  input logic            vsync,
  input logic            reset,
  alien_missile_if.slave bus
);
  localparam int PTR_W = $clog2(NUM_MISSILES);
  localparam int CD_W  = (COOLDOWN < 1) ? 1 : $clog2(COOLDOWN + 1);
  localparam logic [10:0] SPEED_W  = 11'(SPEED);
  localparam logic [10:0] BOTTOM_W = 11'(BOTTOM_Y);

  logic [NUM_MISSILES-1:0]       exists_q, exists_d;
  logic [NUM_MISSILES-1:0][9:0]  x_q, x_d;
  logic [NUM_MISSILES-1:0][9:0]  y_q, y_d;
  logic                          ack_q, ack_d;
  logic [3:0]                    count_q, count_d;
  logic [CD_W-1:0]               cd_q, cd_d;
  logic [PTR_W-1:0]              rr_q, rr_d;

  logic                          found;
  logic [PTR_W-1:0]              slot;
  logic [PTR_W-1:0]              cand;

  always_comb begin
    exists_d = exists_q;
    x_d      = x_q;
    y_d      = y_q;
    ack_d    = 1'b0;
    cd_d     = cd_q;
    rr_d     = rr_q;
    found    = 1'b0;
    slot     = '0;
    cand     = '0;
    count_d  = '0;

    for (int i = 0; i < NUM_MISSILES; i++) begin
      if (exists_q[i]) begin
        if (bus.has_collided[i])
          exists_d[i] = 1'b0;
        else if (({1'b0, y_q[i]} + SPEED_W) > BOTTOM_W)
          exists_d[i] = 1'b0;
        else
          y_d[i] = y_q[i] + 10'(SPEED);
      end
    end

    // Free means free before this edge; a slot retiring now is not reusable until next frame.
    for (int k = 0; k < NUM_MISSILES; k++) begin
      cand = PTR_W'((int'(rr_q) + k) % NUM_MISSILES);
      if (!found && !exists_q[cand]) begin
        found = 1'b1;
        slot  = cand;
      end
    end

    if (bus.fire_req && (cd_q == '0) && found) begin
      exists_d[slot] = 1'b1;
      x_d[slot]      = bus.fire_x + 10'(X_OFFSET);
      y_d[slot]      = bus.fire_y + 10'(Y_OFFSET);
      ack_d          = 1'b1;
      cd_d           = CD_W'(COOLDOWN);
      rr_d           = PTR_W'((int'(slot) + 1) % NUM_MISSILES);
    end else if (cd_q != '0) begin
      cd_d = cd_q - 1'b1;
    end

    for (int i = 0; i < NUM_MISSILES; i++)
      count_d = count_d + 4'(exists_d[i]);
  end

  always_ff @(posedge vsync) begin
    if (reset) begin
      exists_q <= '0;
      x_q      <= '0;
      y_q      <= '0;
      ack_q    <= 1'b0;
      count_q  <= '0;
      cd_q     <= '0;
      rr_q     <= '0;
    end else begin
      exists_q <= exists_d;
      x_q      <= x_d;
      y_q      <= y_d;
      ack_q    <= ack_d;
      count_q  <= count_d;
      cd_q     <= cd_d;
      rr_q     <= rr_d;
    end
  end

  assign bus.fire_ack     = ack_q;
  assign bus.exists       = exists_q;
  assign bus.missile_x    = x_q;
  assign bus.missile_y    = y_q;
  assign bus.active_count = count_q;
endmodule

// File: tb/tb_alien_missile_bank.sv
// Bench for alien_missile_bank: two instances (cooldown 8 and 0) fed the same stimulus,
// directed scenarios followed by random traffic, all checked against a slot-level model.
module tb_alien_missile_bank;
  localparam int N = 4;

  logic vsync = 1'b0;
  logic reset;

  alien_missile_if #(.NUM_MISSILES(N)) bus_a ();
  alien_missile_if #(.NUM_MISSILES(N)) bus_b ();

  alien_missile_bank #(.NUM_MISSILES(N), .COOLDOWN(8)) dut_a (
    .vsync (vsync),
    .reset (reset),
    .bus   (bus_a.slave)
  );

  alien_missile_bank #(.NUM_MISSILES(N), .COOLDOWN(0)) dut_b (
    .vsync (vsync),
    .reset (reset),
    .bus   (bus_b.slave)
  );

  always #5 vsync = ~vsync;

  int n_pass  = 0;
  int n_total = 0;

  // model state, index 0 = cooldown-8 instance, 1 = cooldown-0 instance
  int m_live [2][N];
  int m_x    [2][N];
  int m_y    [2][N];
  int m_cd   [2];
  int m_rr   [2];
  int m_ack  [2];

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic model_reset(int n);
    for (int i = 0; i < N; i++) begin
      m_live[n][i] = 0;
      m_x[n][i]    = 0;
      m_y[n][i]    = 0;
    end
    m_cd[n]  = 0;
    m_rr[n]  = 0;
    m_ack[n] = 0;
  endtask

  task automatic model_edge(int n, int cd_val, bit rst, bit fr, int fx, int fy, int hc);
    int was_live [N];
    int s;
    bit launched;
    if (rst) begin
      model_reset(n);
      return;
    end
    for (int i = 0; i < N; i++) was_live[i] = m_live[n][i];
    for (int i = 0; i < N; i++) begin
      if (was_live[i] != 0) begin
        if (((hc >> i) & 1) != 0)       m_live[n][i] = 0;
        else if (m_y[n][i] + 4 > 479)   m_live[n][i] = 0;
        else                            m_y[n][i] = m_y[n][i] + 4;
      end
    end
    launched = 0;
    s = 0;
    if (fr && m_cd[n] == 0) begin
      for (int k = 0; k < N; k++) begin
        if (!launched && was_live[(m_rr[n] + k) % N] == 0) begin
          s = (m_rr[n] + k) % N;
          launched = 1;
        end
      end
    end
    m_ack[n] = launched;
    if (launched) begin
      m_live[n][s] = 1;
      m_x[n][s]    = (fx + 14) % 1024;
      m_y[n][s]    = (fy + 32) % 1024;
      m_cd[n]      = cd_val;
      m_rr[n]      = (s + 1) % N;
    end else if (m_cd[n] > 0) begin
      m_cd[n] = m_cd[n] - 1;
    end
  endtask

  task automatic check_inst(string nm, int n, logic ack, logic [N-1:0] ex,
                            logic [10*N-1:0] mx, logic [10*N-1:0] my, logic [3:0] cnt);
    int e_ex;
    int e_cnt;
    e_ex = 0;
    e_cnt = 0;
    for (int i = 0; i < N; i++) begin
      e_ex  = e_ex | (m_live[n][i] << i);
      e_cnt = e_cnt + m_live[n][i];
    end
    chk({nm, "_ack"},    32'(ack), 32'(m_ack[n]));
    chk({nm, "_exists"}, 32'(ex),  32'(e_ex));
    chk({nm, "_count"},  32'(cnt), 32'(e_cnt));
    for (int i = 0; i < N; i++) begin
      chk($sformatf("%s_x%0d", nm, i), 32'(mx[10*i +: 10]), 32'(m_x[n][i]));
      chk($sformatf("%s_y%0d", nm, i), 32'(my[10*i +: 10]), 32'(m_y[n][i]));
    end
  endtask

  task automatic step(bit rst, bit fr, int fx, int fy, int hc);
    reset              = rst;
    bus_a.fire_req     = fr;
    bus_a.fire_x       = 10'(fx);
    bus_a.fire_y       = 10'(fy);
    bus_a.has_collided = N'(hc);
    bus_b.fire_req     = fr;
    bus_b.fire_x       = 10'(fx);
    bus_b.fire_y       = 10'(fy);
    bus_b.has_collided = N'(hc);
    @(posedge vsync);
    model_edge(0, 8, rst, fr, fx, fy, hc);
    model_edge(1, 0, rst, fr, fx, fy, hc);
    #1;
    check_inst("a", 0, bus_a.fire_ack, bus_a.exists, bus_a.missile_x, bus_a.missile_y, bus_a.active_count);
    check_inst("b", 1, bus_b.fire_ack, bus_b.exists, bus_b.missile_x, bus_b.missile_y, bus_b.active_count);
  endtask

  initial begin
    model_reset(0);
    model_reset(1);

    // reset overrides a live request and collisions
    step(1, 1, 100, 200, 15);
    chk("t1_exists", 32'(bus_a.exists), 32'd0);
    chk("t1_ack",    32'(bus_a.fire_ack), 32'd0);
    step(0, 0, 0, 0, 0);

    // single launch then three moves
    step(0, 1, 100, 200, 0);
    chk("t2_ack", 32'(bus_a.fire_ack), 32'd1);
    chk("t2_exists", 32'(bus_a.exists), 32'b0001);
    chk("t2_x0", 32'(bus_a.missile_x[9:0]), 32'd114);
    chk("t2_y0", 32'(bus_a.missile_y[9:0]), 32'd232);
    step(0, 0, 0, 0, 0);
    chk("t2_y0_e1", 32'(bus_a.missile_y[9:0]), 32'd236);
    step(0, 0, 0, 0, 0);
    chk("t2_y0_e2", 32'(bus_a.missile_y[9:0]), 32'd240);
    step(0, 0, 0, 0, 0);
    chk("t2_y0_e3", 32'(bus_a.missile_y[9:0]), 32'd244);

    // bottom-edge retirement
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 440, 0);
    chk("t3_y0_launch", 32'(bus_a.missile_y[9:0]), 32'd472);
    step(0, 0, 0, 0, 0);
    chk("t3_y0_move", 32'(bus_a.missile_y[9:0]), 32'd476);
    step(0, 0, 0, 0, 0);
    chk("t3_retired", 32'(bus_a.exists[0]), 32'd0);
    chk("t3_y0_hold", 32'(bus_a.missile_y[9:0]), 32'd476);

    // held request under cooldown 8: acks 9 edges apart
    step(1, 0, 0, 0, 0);
    for (int k = 0; k < 19; k++) begin
      step(0, 1, 20, 0, 0);
      chk($sformatf("t4_ack_k%0d", k), 32'(bus_a.fire_ack),
          32'((k == 0 || k == 9 || k == 18) ? 1 : 0));
    end

    // cooldown 0: fill pool, refuse, retire slot 2, relaunch into it
    step(1, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      step(0, 1, 40 * k, 0, 0);
      chk($sformatf("t5_fill_ack%0d", k), 32'(bus_b.fire_ack), 32'd1);
      chk($sformatf("t5_fill_ex%0d", k), 32'(bus_b.exists[k]), 32'd1);
    end
    step(0, 1, 300, 0, 0);
    chk("t5_full_ack", 32'(bus_b.fire_ack), 32'd0);
    chk("t5_full_cnt", 32'(bus_b.active_count), 32'd4);
    step(0, 1, 300, 0, 4);
    chk("t5_hit_ex2", 32'(bus_b.exists[2]), 32'd0);
    chk("t5_hit_ack", 32'(bus_b.fire_ack), 32'd0);
    step(0, 1, 300, 0, 0);
    chk("t5_relaunch_ack", 32'(bus_b.fire_ack), 32'd1);
    chk("t5_relaunch_x2", 32'(bus_b.missile_x[29:20]), 32'd314);

    // collision coinciding with bottom crossing, plus collision on an empty slot
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 440, 0);
    step(0, 0, 0, 0, 0);
    chk("t6_y1_pre", 32'(bus_b.missile_y[19:10]), 32'd476);
    step(0, 0, 0, 0, 4'b1010);
    chk("t6_exists", 32'(bus_b.exists), 32'b0001);
    chk("t6_ack", 32'(bus_b.fire_ack), 32'd0);
    step(0, 0, 0, 0, 4'b1010);
    chk("t6_exists_after", 32'(bus_b.exists), 32'b0001);

    // random traffic
    for (int t = 0; t < 400; t++) begin
      step(($urandom_range(0, 63) == 0),
           ($urandom_range(0, 1) == 1),
           int'($urandom_range(0, 1023)),
           int'($urandom_range(0, 1023)),
           ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 15)) : 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
